// File: rtl/stream_mux_nto1_pkg.sv
// Shared types for the N-to-1 stream multiplexer.
package stream_mux_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mode_e;

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the search starts after ptr, then priority-encode.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [SW-1:0] grant_idx,
   output logic          grant_valid
);

   logic [N-1:0] rot;
   int unsigned  start;
   int unsigned  off;

   always_comb begin
      start = (32'(ptr) + 32'd1) % N;
      rot   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         rot[k] = req[(start + k) % N];
      end
      grant_valid = 1'b0;
      off         = 0;
      for (int unsigned k = 0; k < N; k++) begin
         if (!grant_valid && rot[k]) begin
            grant_valid = 1'b1;
            off         = k;
         end
      end
      grant_idx = SW'((start + off) % N);
   end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream mux with a single registered output stage; external-select or round-robin.
module stream_mux_nto1
   import stream_mux_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned W  = 8,
   parameter int unsigned SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_ch,
   output logic           out_valid,
   input  logic           out_ready
);

   logic [W-1:0]  out_data_q, out_data_d;
   logic [SW-1:0] out_ch_q,   out_ch_d;
   logic          out_valid_q, out_valid_d;
   logic [SW-1:0] ptr_q,      ptr_d;

   logic [SW-1:0] rr_idx;
   logic          rr_valid;
   logic [SW-1:0] grant_idx;
   logic          grant_valid;
   logic          load;
   mode_e         mode_m;

   rr_arbiter #(
      .N  (N),
      .SW (SW)
   ) u_rr (
      .req         (in_valid),
      .ptr         (ptr_q),
      .grant_idx   (rr_idx),
      .grant_valid (rr_valid)
   );

   always_comb begin
      mode_m      = mode_e'(mode);
      load        = !out_valid_q || out_ready;
      grant_idx   = '0;
      grant_valid = 1'b0;
      if (mode_m == MODE_RR) begin
         grant_idx   = rr_idx;
         grant_valid = rr_valid;
      end else if (32'(sel) < N) begin
         grant_idx   = sel;
         grant_valid = in_valid[sel];
      end
   end

   // Gating with reset keeps any handshake from completing in the reset cycle.
   always_comb begin
      in_ready = '0;
      if (load && grant_valid && !reset) begin
         in_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load) begin
         if (grant_valid) begin
            out_data_d  = in_data[32'(grant_idx)*W +: W];
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            if (mode_m == MODE_RR) begin
               ptr_d = grant_idx;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= SW'(N - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Self-checking bench for stream_mux_nto1 (N=4 main instance plus an N=3 instance for out-of-range select).
module tb_stream_mux_nto1;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   logic           clk;
   logic           reset;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_ch;
   logic           out_valid;
   logic           out_ready;

   logic           mode3;
   logic [1:0]     sel3;
   logic [23:0]    in_data3;
   logic [2:0]     in_valid3;
   logic [2:0]     in_ready3;
   logic [7:0]     out_data3;
   logic [1:0]     out_ch3;
   logic           out_valid3;
   logic           out_ready3;

   int n_checks;
   int n_pass;

   // Reference model state
   bit         m_valid;
   logic [7:0] m_data;
   int         m_ch;
   int         m_ptr;

   stream_mux_nto1 #(.N(4), .W(8)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   stream_mux_nto1 #(.N(3), .W(8)) u_dut3 (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode3),
      .sel       (sel3),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .out_data  (out_data3),
      .out_ch    (out_ch3),
      .out_valid (out_valid3),
      .out_ready (out_ready3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Which channel the spec rules grant this cycle, or -1.
   function automatic int model_grant();
      if (reset) return -1;
      if (m_valid && !out_ready) return -1;
      if (mode == 1'b0) begin
         if (int'(sel) < N && in_valid[sel]) return int'(sel);
         return -1;
      end
      for (int k = 1; k <= N; k++) begin
         if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_ready();
      int g;
      g = model_grant();
      if (g < 0) return 4'b0000;
      return 4'(1 << g);
   endfunction

   task automatic tick();
      int g;
      bit ld;
      ld = !m_valid || out_ready;
      g  = model_grant();
      @(posedge clk);
      if (reset) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         m_ch    = 0;
         m_ptr   = N - 1;
      end else if (ld) begin
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_ch    = g;
            if (mode) m_ptr = g;
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = '0;
      in_valid3 = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      mode      = 1'b1;
      in_valid  = 4'b1111;
      in_data   = $urandom;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got %b exp 0000", in_ready);
      else n_pass++;
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0)
         $display("FAIL reset_outputs got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", out_valid, out_data, out_ch);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) $display("FAIL reset_first_load got %b exp 0001", in_ready);
      else n_pass++;
   endtask

   task automatic test_sel_basic();
      do_reset();
      mode      = 1'b0;
      sel       = 2'd2;
      in_valid  = 4'b0100;
      in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0100) $display("FAIL sel_in_ready got %b exp 0100", in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_data !== 8'hA5 || out_ch !== 2'd2 || out_valid !== 1'b1)
         $display("FAIL sel_output got d=%h ch=%0d v=%b exp d=a5 ch=2 v=1", out_data, out_ch, out_valid);
      else n_pass++;
   endtask

   task automatic test_rr_all();
      do_reset();
      mode      = 1'b1;
      in_valid  = 4'b1111;
      in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_checks++;
         if (in_ready !== 4'(1 << (i % 4))) $display("FAIL rr_all_ready[%0d] got %b exp %b", i, in_ready, 4'(1 << (i % 4)));
         else n_pass++;
         tick();
         n_checks++;
         if (out_ch !== 2'(i % 4) || out_valid !== 1'b1 || out_data !== 8'(8'h10 + i % 4))
            $display("FAIL rr_all_out[%0d] got ch=%0d v=%b d=%h exp ch=%0d v=1 d=%h", i, out_ch, out_valid, out_data, i % 4, 8'(8'h10 + i % 4));
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] held;
      do_reset();
      mode      = 1'b1;
      in_valid  = 4'b1111;
      in_data   = $urandom;
      out_ready = 1'b1;
      tick();
      held      = out_data;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = $urandom;
         #1;
         n_checks++;
         if (in_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b exp 0000", i, in_ready);
         else n_pass++;
         tick();
         n_checks++;
         if (out_data !== held || out_valid !== 1'b1 || out_ch !== 2'd0)
            $display("FAIL bp_hold[%0d] got d=%h v=%b ch=%0d exp d=%h v=1 ch=0", i, out_data, out_valid, out_ch, held);
         else n_pass++;
      end
      out_ready = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         #1;
         n_checks++;
         if (in_ready !== 4'(1 << i)) $display("FAIL bp_release_ready[%0d] got %b exp %b", i, in_ready, 4'(1 << i));
         else n_pass++;
         tick();
         n_checks++;
         if (out_ch !== 2'(i) || out_valid !== 1'b1 || out_data !== in_data[i*8 +: 8])
            $display("FAIL bp_release_out[%0d] got ch=%0d v=%b d=%h exp ch=%0d v=1 d=%h", i, out_ch, out_valid, out_data, i, in_data[i*8 +: 8]);
         else n_pass++;
      end
   endtask

   task automatic test_rr_sparse();
      int exp_seq [3] = '{3, 1, 3};
      do_reset();
      mode      = 1'b1;
      in_valid  = 4'b0010;
      in_data   = $urandom;
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_ch !== 2'd1) $display("FAIL sparse_setup got ch=%0d exp 1", out_ch);
      else n_pass++;
      in_valid = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         in_data = $urandom;
         #1;
         n_checks++;
         if (in_ready !== 4'(1 << exp_seq[i])) $display("FAIL sparse_ready[%0d] got %b exp %b", i, in_ready, 4'(1 << exp_seq[i]));
         else n_pass++;
         tick();
         n_checks++;
         if (out_ch !== 2'(exp_seq[i]) || out_data !== in_data[exp_seq[i]*8 +: 8])
            $display("FAIL sparse_out[%0d] got ch=%0d d=%h exp ch=%0d d=%h", i, out_ch, out_data, exp_seq[i], in_data[exp_seq[i]*8 +: 8]);
         else n_pass++;
      end
   endtask

   task automatic test_sel_invalid();
      do_reset();
      mode      = 1'b0;
      sel       = 2'd1;
      in_valid  = 4'b0010;
      in_data   = {8'h44, 8'h33, 8'h77, 8'h11};
      out_ready = 1'b0;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h77) $display("FAIL selinv_preload got v=%b d=%h exp v=1 d=77", out_valid, out_data);
      else n_pass++;
      sel      = 2'd0;
      in_valid = 4'b1110;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) $display("FAIL selinv_stall_ready got %b exp 0000", in_ready);
      else n_pass++;
      tick();
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) $display("FAIL selinv_ready got %b exp 0000", in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h77 || out_ch !== 2'd1)
         $display("FAIL selinv_drain got v=%b d=%h ch=%0d exp v=0 d=77 ch=1", out_valid, out_data, out_ch);
      else n_pass++;

      mode3      = 1'b0;
      sel3       = 2'd1;
      in_valid3  = 3'b111;
      in_data3   = {8'h33, 8'h22, 8'h11};
      out_ready3 = 1'b1;
      #1;
      n_checks++;
      if (in_ready3 !== 3'b010) $display("FAIL n3_ready got %b exp 010", in_ready3);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid3 !== 1'b1 || out_ch3 !== 2'd1 || out_data3 !== 8'h22)
         $display("FAIL n3_load got v=%b ch=%0d d=%h exp v=1 ch=1 d=22", out_valid3, out_ch3, out_data3);
      else n_pass++;
      sel3 = 2'd3;
      #1;
      n_checks++;
      if (in_ready3 !== 3'b000) $display("FAIL n3_oor_ready got %b exp 000", in_ready3);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid3 !== 1'b0 || out_data3 !== 8'h22 || out_ch3 !== 2'd1)
         $display("FAIL n3_oor_drain got v=%b d=%h ch=%0d exp v=0 d=22 ch=1", out_valid3, out_data3, out_ch3);
      else n_pass++;
      in_valid3 = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      mode      = 1'b1;
      in_valid  = 4'b1111;
      in_data   = $urandom;
      out_ready = 1'b0;
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b1) $display("FAIL rmid_loaded got v=%b exp 1", out_valid);
      else n_pass++;
      reset     = 1'b1;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) $display("FAIL rmid_ready got %b exp 0000", in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0)
         $display("FAIL rmid_cleared got v=%b d=%h ch=%0d exp v=0 d=00 ch=0", out_valid, out_data, out_ch);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 4'b0001) $display("FAIL rmid_first_grant got %b exp 0001", in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (out_ch !== 2'd0 || out_data !== in_data[7:0]) $display("FAIL rmid_first_out got ch=%0d d=%h exp ch=0 d=%h", out_ch, out_data, in_data[7:0]);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 40) == 0);
         mode      = 1'($urandom);
         sel       = 2'($urandom);
         in_valid  = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         n_checks++;
         if (in_ready !== model_ready()) $display("FAIL rand_ready[%0d] got %b exp %b", i, in_ready, model_ready());
         else n_pass++;
         tick();
         n_checks++;
         if (out_valid !== m_valid || out_data !== m_data || out_ch !== 2'(m_ch))
            $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d exp v=%b d=%h ch=%0d", i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
         else n_pass++;
      end
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      m_valid    = 1'b0;
      m_data     = 8'h00;
      m_ch       = 0;
      m_ptr      = N - 1;
      reset      = 1'b1;
      mode       = 1'b0;
      sel        = '0;
      in_data    = '0;
      in_valid   = '0;
      out_ready  = 1'b0;
      mode3      = 1'b0;
      sel3       = '0;
      in_data3   = '0;
      in_valid3  = '0;
      out_ready3 = 1'b0;
      #1;
      test_reset();
      test_sel_basic();
      test_rr_all();
      test_backpressure();
      test_rr_sparse();
      test_sel_invalid();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
